// File: rtl/apb_slave_mem.sv
// APB completer backed by a byte-wide register file.
// A configurable number of wait states is inserted in each access phase.
// Out-of-range addresses and writes into the read-only window complete with PSLVERR.
// PREADY, PRDATA and PSLVERR are decoded from registered state only.
module apb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int RO_BASE     = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic       PCLK,
  input  logic       PRST,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic       PREADY,
  output logic [7:0] PRDATA,
  output logic       PSLVERR
);

  localparam logic [8:0] DEPTH_L = 9'(MEM_DEPTH);
  localparam logic [8:0] RO_L    = 9'(RO_BASE);
  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       write_q, write_d;
  logic       err_q, err_d;
  logic       mem_we_s;
  logic       ready_s;
  logic [7:0] mem_q [0:255];

  // The access is rejected if the address is unimplemented, or if it is a write into the read-only window.
  function automatic logic calc_err(input logic [7:0] addr, input logic wr);
    return ({1'b0, addr} >= DEPTH_L) || (wr && ({1'b0, addr} >= RO_L));
  endfunction

  // Next-state logic: capture on setup, count wait states, and finish on completion or abort.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    write_d  = write_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = S_ACCESS;
          wcnt_d  = 4'd0;
          addr_d  = PADDR;
          data_d  = PWDATA;
          write_d = PWRITE;
          err_d   = calc_err(PADDR, PWRITE);
        end else begin
          // PSEL with PENABLE and no preceding setup phase is ignored.
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (PSEL && PENABLE) begin
          if (wcnt_q == WS_L) begin
            mem_we_s = write_q & ~err_q;
            state_d  = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end else begin
          // An aborted access returns to IDLE without a write or an error.
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transfer-control registers.
  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Storage array: cleared on reset and written only on an error-free write completion edge.
  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we_s) begin
      mem_q[addr_q] <= data_q;
    end else begin
      mem_q[addr_q] <= mem_q[addr_q];
    end
  end

  // Response decode from registered state only; read data is forced to zero unless it is a good read.
  always_comb begin
    ready_s = (state_q == S_ACCESS) && (wcnt_q == WS_L);
    PREADY  = ready_s;
    PSLVERR = ready_s & err_q;
    if (ready_s && !write_q && !err_q) begin
      PRDATA = mem_q[addr_q];
    end else begin
      PRDATA = 8'h00;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem.
// Three instances are exercised:
//   k=0: defaults (256 bytes, no read-only window, no wait states)
//   k=1: 128 bytes, read-only from 0x60, 3 wait states
//   k=2: 256 bytes, 2 wait states
// Each instance is compared against an array model of its memory contents.
module tb_apb_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       prst    [3];
  logic       psel    [3];
  logic       pen     [3];
  logic       pwr     [3];
  logic [7:0] padr    [3];
  logic [7:0] pwd     [3];
  logic       pready  [3];
  logic [7:0] prdata  [3];
  logic       pslverr [3];

  int checks = 0;
  int errors = 0;
  logic [7:0] model [3][256];

  apb_slave_mem #(.MEM_DEPTH(256), .RO_BASE(256), .WAIT_STATES(0)) u_a (
    .PCLK(clk), .PRST(prst[0]), .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(padr[0]), .PWDATA(pwd[0]), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.MEM_DEPTH(128), .RO_BASE(96), .WAIT_STATES(3)) u_b (
    .PCLK(clk), .PRST(prst[1]), .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(padr[1]), .PWDATA(pwd[1]), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.MEM_DEPTH(256), .RO_BASE(256), .WAIT_STATES(2)) u_c (
    .PCLK(clk), .PRST(prst[2]), .PSEL(psel[2]), .PENABLE(pen[2]), .PWRITE(pwr[2]),
    .PADDR(padr[2]), .PWDATA(pwd[2]), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  function automatic int dep(input int k);
    return (k == 1) ? 128 : 256;
  endfunction
  function automatic int rob(input int k);
    return (k == 1) ? 96 : 256;
  endfunction
  function automatic int wst(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input int k, input string tag);
    chk({tag, " PREADY"},  {7'd0, pready[k]},  8'h00);
    chk({tag, " PRDATA"},  prdata[k],          8'h00);
    chk({tag, " PSLVERR"}, {7'd0, pslverr[k]}, 8'h00);
  endtask

  // Full transfer starting at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input bit exp_err, input string tag);
    bit merr;
    merr = (int'(a) >= dep(k)) || (wr && (int'(a) >= rob(k)));
    psel[k] = 1'b1; pen[k] = 1'b0; pwr[k] = wr; padr[k] = a; pwd[k] = d;
    @(negedge clk);
    chk({tag, " setup PREADY"}, {7'd0, pready[k]}, 8'h00);
    @(posedge clk); #1;
    pen[k] = 1'b1;
    // The bus fields are scrambled during the access phase; the captured values must be used.
    padr[k] = 8'($urandom); pwd[k] = 8'($urandom); pwr[k] = 1'($urandom);
    for (int c = 0; c < wst(k); c++) begin
      @(negedge clk);
      chk_quiet(k, {tag, " wait"});
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, " done PREADY"},  {7'd0, pready[k]},  8'h01);
    chk({tag, " done PRDATA"},  prdata[k],          exp_rd);
    chk({tag, " done PSLVERR"}, {7'd0, pslverr[k]}, {7'd0, exp_err});
    @(posedge clk); #1;
    psel[k] = 1'b0; pen[k] = 1'b0;
    if (wr && !merr) model[k][a] = d;
  endtask

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    bit         err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit         wr, err;
    int         k;
    logic [7:0] a, d, rd;
    logic [7:0] edges [4];

    tbl[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
    tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
    tbl[2]  = '{1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1, 1'b1, 8'h80, 8'h33, 8'h00, 1'b1};
    tbl[4]  = '{1, 1'b1, 8'h60, 8'h44, 8'h00, 1'b1};
    tbl[5]  = '{1, 1'b0, 8'h60, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{1, 1'b1, 8'h5F, 8'h3C, 8'h00, 1'b0};
    tbl[8]  = '{1, 1'b0, 8'h5F, 8'h00, 8'h3C, 1'b0};
    tbl[9]  = '{1, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
    tbl[11] = '{0, 1'b1, 8'hFF, 8'h11, 8'h00, 1'b0};
    tbl[12] = '{0, 1'b0, 8'hFF, 8'h00, 8'h11, 1'b0};
    tbl[13] = '{2, 1'b1, 8'h05, 8'h5A, 8'h00, 1'b0};
    edges[0] = 8'h5F; edges[1] = 8'h60; edges[2] = 8'h7F; edges[3] = 8'h80;

    for (int i = 0; i < 3; i++) begin
      prst[i] = 1'b0; psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0;
      padr[i] = 8'h00; pwd[i] = 8'h00;
      for (int j = 0; j < 256; j++) model[i][j] = 8'h00;
    end

    #2;
    for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) prst[i] = 1'b1;

    // Protocol violation: PSEL and PENABLE from IDLE with no setup phase.
    psel[0] = 1'b1; pen[0] = 1'b1; pwr[0] = 1'b1; pwd[0] = 8'hFF; padr[0] = 8'h01;
    repeat (3) begin
      @(negedge clk);
      chk({"violation PREADY"}, {7'd0, pready[0]}, 8'h00);
      @(posedge clk); #1;
    end
    psel[0] = 1'b0; pen[0] = 1'b0;
    xfer(0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, "violation readback");

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      xfer(tbl[i].k, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].err, $sformatf("tbl%0d", i));
    end

    // Abort: a write is set up, then PSEL drops during a wait cycle.
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1; padr[1] = 8'h20; pwd[1] = 8'h77;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(negedge clk);
    chk("abort wait PREADY", {7'd0, pready[1]}, 8'h00);
    @(posedge clk); #1;
    psel[1] = 1'b0;
    @(negedge clk);
    chk("abort drop PREADY", {7'd0, pready[1]}, 8'h00);
    @(posedge clk); #1;
    pen[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet(1, "abort idle");
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, "abort readback");

    // Reset during a wait cycle of a read that follows a completed write.
    xfer(2, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, "pre-reset read");
    psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b0; padr[2] = 8'h05;
    @(posedge clk); #1;
    pen[2] = 1'b1;
    @(posedge clk); #3;
    prst[2] = 1'b0;
    #1;
    chk_quiet(2, "mid reset");
    psel[2] = 1'b0; pen[2] = 1'b0;
    @(posedge clk); #1;
    prst[2] = 1'b1;
    for (int j = 0; j < 256; j++) model[2][j] = 8'h00;
    xfer(2, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, "post-reset read");

    // Randomized transfers against the model.
    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(2);
      wr = 1'($urandom_range(1));
      case ($urandom_range(2))
        0:       a = 8'($urandom);
        1:       a = edges[$urandom_range(3)];
        default: a = 8'h5C + 8'($urandom_range(7));
      endcase
      d   = 8'($urandom);
      err = (int'(a) >= dep(k)) || (wr && (int'(a) >= rob(k)));
      rd  = (!wr && !err) ? model[k][a] : 8'h00;
      xfer(k, wr, a, d, rd, err, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer stage directly downstream of the team's APB master.
- Consumes PSELx, PENABLE, PWRITE, padd[7:0] and pwdata; returns PREADY, prdata and PSLVERR.
- Backs an 8-bit-wide register file with a configurable wait-state count and address/permission error reporting.
- Two instances sit behind the master: padd[8]=0 drives PSEL1 to instance 0, padd[8]=1 drives PSEL2 to instance 1.

Parameters:
- MEM_DEPTH, 256: number of implemented byte locations (1..256). Addresses >= MEM_DEPTH are invalid.
- RO_BASE, 256: first read-only address. Writes at or above RO_BASE error. 256 means no read-only region.
- WAIT_STATES, 0: PREADY-low cycles inserted in each access phase (0..15).

Ports:
- PCLK  input  1  APB clock; all state updates on rising edge.
- PRST  input  1  asynchronous, active-low reset.
- PSEL  input  1  slave select (PSEL1 or PSEL2 from master).
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  byte address (master padd[7:0]).
- PWDATA  input  8  write data.
- PREADY  output  1  transfer completes on the edge where PSEL & PENABLE & PREADY.
- PRDATA  output  8  read data; valid only while PREADY=1 on a read.
- PSLVERR  output  1  error flag; valid only while PREADY=1.

Behaviour:
- Reset (PRST=0, asynchronous): state=IDLE, wait counter=0, captured address/data/direction=0, all memory bytes=0x00, PREADY=0, PRDATA=0x00, PSLVERR=0.
- States:
  - IDLE: PREADY=0.
  - ACCESS: PREADY = (wcnt == WAIT_STATES).
- IDLE -> ACCESS on an edge with PSEL=1 and PENABLE=0 (setup phase).
  - Capture PADDR, PWRITE and PWDATA at that edge.
  - Clear wcnt to 0.
  - Compute err_c: captured addr >= MEM_DEPTH, or (write and addr >= RO_BASE).
- In IDLE, PSEL=1 with PENABLE=1 (no preceding setup) is a protocol violation: ignore it, stay IDLE, keep PREADY=0.
- ACCESS, PSEL=1, PENABLE=1, wcnt < WAIT_STATES: increment wcnt, stay in ACCESS. wcnt saturates at WAIT_STATES.
- ACCESS, PSEL=1, PENABLE=1, PREADY=1 (completion edge):
  - Write with err_c=0: mem[addr] <= captured data.
  - Go to IDLE.
  - The next setup phase is seen from IDLE, so back-to-back transfers cost a minimum of 2+WAIT_STATES cycles each.
- ACCESS with PSEL=0 or PENABLE=0 (aborted access): go to IDLE. No memory write, no error, PREADY drops.
- Transfer latency: setup edge to completion edge is 1+WAIT_STATES cycles; PREADY is high during the final cycle only.
- PRDATA:
  - Read, PREADY=1, err_c=0: mem[captured addr].
  - Read, PREADY=1, err_c=1: 0x00.
  - All other cycles: 0x00.
- PSLVERR = PREADY & err_c; 0 at all other times.
- Errored writes leave memory unchanged. Errored reads still complete with PREADY.
- PADDR, PWDATA and PWRITE changes during ACCESS are ignored; captured values are used.
- Memory is written only on the completion edge. A read of an address written by the immediately preceding transfer returns the new data.
- PRST asserted mid-transfer: immediate return to IDLE, memory cleared, outputs to reset values. No partial write survives.
- PREADY, PRDATA and PSLVERR are combinational from registered state only, never from bus inputs. This gives no combinational path PSEL/PENABLE -> PREADY.

Test Plan:
- Reset, WAIT_STATES=0: write 0xA5 to addr 0x10, then read 0x10 -> PREADY high in the access cycle of each transfer, PRDATA=0xA5, PSLVERR=0 throughout.
- WAIT_STATES=3: read addr 0x00 -> PREADY low for 3 access cycles, high on the 4th, PRDATA=0x00. Total setup-to-completion = 4 cycles.
- MEM_DEPTH=128, RO_BASE=0x60: write 0x33 to 0x80 -> PSLVERR=1 with PREADY. Write 0x44 to 0x60 -> PSLVERR=1, and a subsequent read of 0x60 returns 0x00. Read 0x90 -> PSLVERR=1, PRDATA=0x00.
- Abort: setup write 0x77 to 0x20, then drop PSEL in the access phase -> return to IDLE, no PREADY pulse, and a later read of 0x20 returns 0x00.
- Reset mid-access: WAIT_STATES=2, after a write of 0x5A to 0x05 completes, start a read of 0x05 and pulse PRST low during a wait cycle -> PREADY=0 immediately, and a read of 0x05 after reset returns 0x00.
- Protocol violation: PSEL=1, PENABLE=1 from IDLE with PWRITE=1, PWDATA=0xFF, PADDR=0x01 -> PREADY stays 0, and mem[0x01] remains 0x00.
